// File: rtl/udp_outbound_chain_tx_if.sv
// ---------------------------------------------------------------------------
// udp_outbound_chain_tx_if
// Purpose : bundles the request, FIFO and transmit-side signals of the UDP
//           chain-packet transmitter into one port.
// Signals : start/hop_count/submsg_count  - packet request (sampled on accept)
//           hdr_addr/hdr_len/hdr_empty/hdr_rd - showahead header FIFO
//           pl_d/pl_empty/pl_rd           - showahead payload FIFO
//           txd/txdv/txlast               - outbound byte stream
//           busy/underrun                 - status
// Modports: master - requester/FIFO/sink side
//           slave  - the transmitter
// ---------------------------------------------------------------------------
interface udp_outbound_chain_tx_if;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FIELD_W = 16;
  localparam int unsigned SUB_W   = 8;

  logic               start;
  logic [FIELD_W-1:0] hop_count;
  logic [SUB_W-1:0]   submsg_count;

  logic [FIELD_W-1:0] hdr_addr;
  logic [FIELD_W-1:0] hdr_len;
  logic               hdr_empty;
  logic               hdr_rd;

  logic [BYTE_W-1:0]  pl_d;
  logic               pl_empty;
  logic               pl_rd;

  logic [BYTE_W-1:0]  txd;
  logic               txdv;
  logic               txlast;
  logic               busy;
  logic               underrun;

  modport master (
    output start, hop_count, submsg_count,
    output hdr_addr, hdr_len, hdr_empty,
    output pl_d, pl_empty,
    input  hdr_rd, pl_rd,
    input  txd, txdv, txlast, busy, underrun
  );

  modport slave (
    input  start, hop_count, submsg_count,
    input  hdr_addr, hdr_len, hdr_empty,
    input  pl_d, pl_empty,
    output hdr_rd, pl_rd,
    output txd, txdv, txlast, busy, underrun
  );
endinterface

// File: rtl/udp_outbound_chain_tx.sv
// ---------------------------------------------------------------------------
// udp_outbound_chain_tx
// Purpose : serialises one chain packet per accepted start: protocol id
//           0x4321 and hop count (little-endian), then per submessage a
//           4-byte record (addr, len) followed by len payload bytes pulled
//           from a showahead payload FIFO. One byte per cycle, no gaps.
// Ports   : clk  - sole clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - udp_outbound_chain_tx_if.slave (request, header FIFO,
//                  payload FIFO, tx stream, busy, sticky underrun)
// Output timing: the tx stream and FIFO pops are decoded from the current
// state each cycle; payload bytes pass straight from pl_d to txd so the pop
// and the emitted byte line up in the same cycle.
// ---------------------------------------------------------------------------
module udp_outbound_chain_tx (
  input  logic                    clk,
  input  logic                    rst,
  udp_outbound_chain_tx_if.slave  bus
);
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FIELD_W = 16;
  localparam int unsigned SUB_W   = 8;

  localparam logic [FIELD_W-1:0] PROTO_ID  = FIELD_W'(16'h4321);
  localparam logic [FIELD_W-1:0] MISS_ADDR = FIELD_W'(16'hFFFF);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PROTO_LO,
    S_PROTO_HI,
    S_HOP_LO,
    S_HOP_HI,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [FIELD_W-1:0] r_hop;
  logic [BYTE_W-1:0]  r_addr_hi;
  logic [FIELD_W-1:0] r_len;
  logic [FIELD_W-1:0] r_len_cnt;
  logic [SUB_W-1:0]   r_sub_rem;
  logic               r_hdr_ok;
  logic               r_underrun;

  logic               w_accept;
  logic               w_more_subs;
  logic               w_sub_end;
  logic [FIELD_W-1:0] w_hdr_addr;
  logic [FIELD_W-1:0] w_hdr_len;

  logic [BYTE_W-1:0]  w_txd;
  logic               w_txdv;
  logic               w_txlast;
  logic               w_hdr_rd;
  logic               w_pl_rd;

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  // r_sub_rem counts submessages not yet finished, including the current one
  assign w_more_subs = (r_sub_rem > SUB_W'(1));

  // A starved header FIFO yields a substitute record: addr 0xFFFF, len 0
  assign w_hdr_addr  = bus.hdr_empty ? MISS_ADDR : bus.hdr_addr;
  assign w_hdr_len   = bus.hdr_empty ? FIELD_W'(0) : bus.hdr_len;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle byte/pop decode
  always_comb begin
    w_next    = r_state;
    w_txd     = '0;
    w_txdv    = 1'b0;
    w_txlast  = 1'b0;
    w_hdr_rd  = 1'b0;
    w_pl_rd   = 1'b0;
    w_sub_end = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_PROTO_LO;
        end
      end
      S_PROTO_LO: begin
        w_txdv = 1'b1;
        w_txd  = PROTO_ID[BYTE_W-1:0];
        w_next = S_PROTO_HI;
      end
      S_PROTO_HI: begin
        w_txdv = 1'b1;
        w_txd  = PROTO_ID[FIELD_W-1:BYTE_W];
        w_next = S_HOP_LO;
      end
      S_HOP_LO: begin
        w_txdv = 1'b1;
        w_txd  = r_hop[BYTE_W-1:0];
        w_next = S_HOP_HI;
      end
      S_HOP_HI: begin
        w_txdv = 1'b1;
        w_txd  = r_hop[FIELD_W-1:BYTE_W];
        if (r_sub_rem != SUB_W'(0)) begin
          w_next = S_ADDR_LO;
        end else begin
          w_txlast = 1'b1;
          w_next   = S_IDLE;
        end
      end
      S_ADDR_LO: begin
        // low address byte comes straight from the FIFO head being latched
        w_txdv = 1'b1;
        w_txd  = w_hdr_addr[BYTE_W-1:0];
        w_next = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        w_txdv = 1'b1;
        w_txd  = r_addr_hi;
        w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_txdv = 1'b1;
        w_txd  = r_len[BYTE_W-1:0];
        w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_txdv   = 1'b1;
        w_txd    = r_len[FIELD_W-1:BYTE_W];
        w_hdr_rd = r_hdr_ok;
        if (r_len != FIELD_W'(0)) begin
          w_next = S_PAYLOAD;
        end else begin
          w_sub_end = 1'b1;
        end
      end
      S_PAYLOAD: begin
        // a starved byte is sent as 0x00 and still counts toward len
        w_txdv  = 1'b1;
        w_pl_rd = ~bus.pl_empty;
        w_txd   = bus.pl_empty ? BYTE_W'(0) : bus.pl_d;
        if (r_len_cnt == FIELD_W'(1)) begin
          w_sub_end = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // End of a submessage: loop to the next record or close the packet
    if (w_sub_end) begin
      if (w_more_subs) begin
        w_next = S_ADDR_LO;
      end else begin
        w_txlast = 1'b1;
        w_next   = S_IDLE;
      end
    end

    // A reset cycle truncates the packet: no txlast and no FIFO pops
    if (rst) begin
      w_txlast = 1'b0;
      w_hdr_rd = 1'b0;
      w_pl_rd  = 1'b0;
    end
  end

  // Packet fields, submessage/length counters and sticky underrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hop      <= '0;
      r_addr_hi  <= '0;
      r_len      <= '0;
      r_len_cnt  <= '0;
      r_sub_rem  <= '0;
      r_hdr_ok   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hop      <= bus.hop_count;
        r_sub_rem  <= bus.submsg_count;
        r_underrun <= 1'b0;
      end
      if (r_state == S_ADDR_LO) begin
        r_addr_hi <= w_hdr_addr[FIELD_W-1:BYTE_W];
        r_len     <= w_hdr_len;
        r_hdr_ok  <= ~bus.hdr_empty;
        if (bus.hdr_empty) begin
          r_underrun <= 1'b1;
        end
      end
      if (r_state == S_LEN_HI) begin
        r_len_cnt <= r_len;
      end
      if (r_state == S_PAYLOAD) begin
        r_len_cnt <= r_len_cnt - FIELD_W'(1);
        if (bus.pl_empty) begin
          r_underrun <= 1'b1;
        end
      end
      if (w_sub_end) begin
        r_sub_rem <= r_sub_rem - SUB_W'(1);
      end
    end
  end

  assign bus.txd      = w_txd;
  assign bus.txdv     = w_txdv;
  assign bus.txlast   = w_txlast;
  assign bus.hdr_rd   = w_hdr_rd;
  assign bus.pl_rd    = w_pl_rd;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.underrun = r_underrun;

endmodule
